// File: rtl/loop_perf_monitor.sv
// Loop profiler for HLS kernels: per-loop trip, iteration, active/stall cycle and
// latency counters derived from the FSM state vector, read through one registered port.
module loop_perf_monitor #(
  parameter int NUM_LOOPS = 4,
  parameter int STATE_W   = 16,
  parameter int CNT_W     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [STATE_W-1:0]           cur_state,
  input  logic [NUM_LOOPS*STATE_W-1:0] body_mask,
  input  logic [NUM_LOOPS-1:0]         iter_start,
  input  logic [NUM_LOOPS-1:0]         iter_end,
  input  logic [NUM_LOOPS-1:0]         stall,
  input  logic                         freeze,
  input  logic                         clr,
  input  logic                         rd_req,
  input  logic [3:0]                   rd_loop,
  input  logic [2:0]                   rd_sel,
  output logic                         rd_valid,
  output logic [CNT_W-1:0]             rd_data,
  output logic [NUM_LOOPS-1:0]         busy
);

  typedef enum logic {CH_IDLE, CH_ACTIVE} ch_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] trips;
    logic [CNT_W-1:0] iters_started;
    logic [CNT_W-1:0] iters_ended;
    logic [CNT_W-1:0] active_cycles;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] max_latency;
  } counters_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  counters_t [NUM_LOOPS-1:0] cnt_all;
  logic      [NUM_LOOPS-1:0] ovf_all;
  logic      [NUM_LOOPS-1:0] flight_all;

  for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_ch
    ch_state_e        st_q, st_d;
    counters_t        cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             ovf_q, ovf_d;
    logic             in_body;
    logic             sat_hit;

    assign in_body = |(cur_state & body_mask[g*STATE_W +: STATE_W]);

    // NOTE: every always_comb output is given its hold value first, so no path infers a latch.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      ovf_d   = ovf_q;
      sat_hit = 1'b0;
      if (clr) begin
        st_d  = CH_IDLE;
        cnt_d = '0;
        lat_d = '0;
        ovf_d = 1'b0;
      end else if (!freeze) begin
        if (in_body) begin
          if (iter_start[g]) begin
            sat_hit             = sat_hit | (cnt_q.iters_started == CNT_MAX);
            cnt_d.iters_started = sat_inc(cnt_q.iters_started);
          end
          if (iter_end[g]) begin
            sat_hit           = sat_hit | (cnt_q.iters_ended == CNT_MAX);
            cnt_d.iters_ended = sat_inc(cnt_q.iters_ended);
          end
          if (stall[g]) begin
            sat_hit            = sat_hit | (cnt_q.stall_cycles == CNT_MAX);
            cnt_d.stall_cycles = sat_inc(cnt_q.stall_cycles);
          end
          // The entry cycle counts as an active cycle, so a k-cycle trip adds k.
          sat_hit             = sat_hit | (cnt_q.active_cycles == CNT_MAX);
          cnt_d.active_cycles = sat_inc(cnt_q.active_cycles);
          if (st_q == CH_IDLE) begin
            st_d        = CH_ACTIVE;
            sat_hit     = sat_hit | (cnt_q.trips == CNT_MAX);
            cnt_d.trips = sat_inc(cnt_q.trips);
            lat_d       = CNT_W'(1);
          end else begin
            sat_hit = sat_hit | (lat_q == CNT_MAX);
            lat_d   = sat_inc(lat_q);
          end
        end else if (st_q == CH_ACTIVE) begin
          st_d               = CH_IDLE;
          cnt_d.last_latency = lat_q;
          if (lat_q > cnt_q.max_latency) cnt_d.max_latency = lat_q;
        end
        ovf_d = ovf_q | sat_hit;
      end
    end

    // NOTE: state uses non-blocking assignments so all channels update from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st_q  <= CH_IDLE;
        cnt_q <= '0;
        lat_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lat_q <= lat_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_all[g]    = cnt_q;
    assign ovf_all[g]    = ovf_q;
    assign flight_all[g] = (cnt_q.iters_started != cnt_q.iters_ended);
    assign busy[g]       = (st_q == CH_ACTIVE);
  end

  // Out-of-range channel indices match no channel and read back as zero.
  logic [CNT_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (rd_loop == i[3:0]) begin
        case (rd_sel)
          3'd0: rd_mux = cnt_all[i].trips;
          3'd1: rd_mux = cnt_all[i].iters_started;
          3'd2: rd_mux = cnt_all[i].iters_ended;
          3'd3: rd_mux = cnt_all[i].active_cycles;
          3'd4: rd_mux = cnt_all[i].stall_cycles;
          3'd5: rd_mux = cnt_all[i].last_latency;
          3'd6: rd_mux = cnt_all[i].max_latency;
          3'd7: rd_mux = CNT_W'({flight_all[i], ovf_all[i], busy[i]});
        endcase
      end
    end
  end

  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_mux;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
